// File: rtl/pep_ks_ctrl_cmd_gen.sv
// Key-switch command generator: allocates batch slots for sequencer requests and
// expands each batch into COL_NB round-robin interleaved commands for the KS feed FIFO.
module pep_ks_ctrl_cmd_gen #(
    parameter int TOTAL_BATCH_NB   = 2,
    parameter int KS_BLOCK_COL_NB  = 4,
    parameter int BATCH_PBS_NB     = 8,
    parameter int TOTAL_PBS_NB     = 16,
    parameter int BATCH_NB         = TOTAL_BATCH_NB,
    parameter int COL_NB           = KS_BLOCK_COL_NB,
    parameter int PID_W            = $clog2(TOTAL_PBS_NB),
    parameter int BPBS_ID_W        = $clog2(BATCH_PBS_NB),
    parameter int TOTAL_BATCH_NB_W = (TOTAL_BATCH_NB > 1) ? $clog2(TOTAL_BATCH_NB) : 1,
    parameter int KS_LOOP_W        = (COL_NB > 1) ? $clog2(COL_NB) : 1,
    parameter int PROC_CMD_W       = TOTAL_BATCH_NB_W + BATCH_NB + PID_W + BPBS_ID_W + KS_LOOP_W
) (
    input  logic                        clk,
    input  logic                        a_rst,
    input  logic                        reset_cache,
    input  logic [PID_W-1:0]            seq_ks_first_pid,
    input  logic [BPBS_ID_W:0]          seq_ks_pbs_nb,
    input  logic                        seq_ks_vld,
    output logic                        seq_ks_rdy,
    output logic [TOTAL_BATCH_NB_W-1:0] seq_ks_batch_id,
    output logic [PROC_CMD_W-1:0]       ffifo_feed_pcmd,
    output logic                        ffifo_feed_vld,
    input  logic                        ffifo_feed_rdy,
    output logic                        batch_done,
    output logic [TOTAL_BATCH_NB_W-1:0] batch_done_id
);

    typedef struct packed {
        logic [TOTAL_BATCH_NB_W-1:0] batch_id;
        logic [BATCH_NB-1:0]         batch_id_1h;
        logic [PID_W-1:0]            first_pid;
        logic [BPBS_ID_W-1:0]        pbs_cnt_max;
        logic [KS_LOOP_W-1:0]        ks_loop;
    } proc_cmd_t;

    localparam logic [KS_LOOP_W-1:0]        LAST_COL  = KS_LOOP_W'(COL_NB - 1);
    localparam logic [TOTAL_BATCH_NB_W-1:0] LAST_SLOT = TOTAL_BATCH_NB_W'(BATCH_NB - 1);

    logic [BATCH_NB-1:0]         active_q, active_d;
    logic [BATCH_NB-1:0]         pend_q, pend_d;
    logic [PID_W-1:0]            pid_q  [BATCH_NB];
    logic [PID_W-1:0]            pid_d  [BATCH_NB];
    logic [BPBS_ID_W-1:0]        pmax_q [BATCH_NB];
    logic [BPBS_ID_W-1:0]        pmax_d [BATCH_NB];
    logic [KS_LOOP_W-1:0]        col_q  [BATCH_NB];
    logic [KS_LOOP_W-1:0]        col_d  [BATCH_NB];
    logic [TOTAL_BATCH_NB_W-1:0] rr_q, rr_d;
    logic                        out_vld_q, out_vld_d;
    proc_cmd_t                   out_cmd_q, out_cmd_d;
    logic                        done_q, done_d;
    logic [TOTAL_BATCH_NB_W-1:0] done_id_q, done_id_d;

    logic                        alloc_vld;
    logic [TOTAL_BATCH_NB_W-1:0] alloc_id;
    logic                        cand_vld;
    logic [TOTAL_BATCH_NB_W-1:0] cand_id;
    logic                        alloc, load_ok, issue, last_acc;

    // Lowest-index free slot; pending_free slots stay active so they are not reused early.
    always_comb begin
        alloc_vld = 1'b0;
        alloc_id  = '0;
        for (int i = BATCH_NB - 1; i >= 0; i--) begin
            if (!active_q[i]) begin
                alloc_vld = 1'b1;
                alloc_id  = TOTAL_BATCH_NB_W'(i);
            end
        end
    end

    // First issuable slot at or after the round-robin pointer.
    always_comb begin
        logic [TOTAL_BATCH_NB_W-1:0] idx;
        cand_vld = 1'b0;
        cand_id  = '0;
        idx      = '0;
        for (int k = 0; k < BATCH_NB; k++) begin
            idx = TOTAL_BATCH_NB_W'((int'(rr_q) + k) % BATCH_NB);
            if (!cand_vld && active_q[idx] && !pend_q[idx]) begin
                cand_vld = 1'b1;
                cand_id  = idx;
            end
        end
    end

    assign seq_ks_rdy      = alloc_vld && !reset_cache;
    assign seq_ks_batch_id = alloc_id;
    assign alloc           = seq_ks_vld && seq_ks_rdy;
    assign load_ok         = !out_vld_q || ffifo_feed_rdy;
    assign issue           = cand_vld && load_ok && !reset_cache;
    assign last_acc        = out_vld_q && ffifo_feed_rdy && (out_cmd_q.ks_loop == LAST_COL);

    always_comb begin
        active_d  = active_q;
        pend_d    = pend_q;
        pid_d     = pid_q;
        pmax_d    = pmax_q;
        col_d     = col_q;
        rr_d      = rr_q;
        out_vld_d = out_vld_q;
        out_cmd_d = out_cmd_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;

        if (alloc) begin
            active_d[alloc_id] = 1'b1;
            pend_d[alloc_id]   = 1'b0;
            pid_d[alloc_id]    = seq_ks_first_pid;
            pmax_d[alloc_id]   = BPBS_ID_W'(seq_ks_pbs_nb - 1'b1);
            col_d[alloc_id]    = '0;
        end

        if (load_ok) begin
            out_vld_d = issue;
        end

        if (issue) begin
            out_cmd_d.batch_id    = cand_id;
            out_cmd_d.batch_id_1h = BATCH_NB'(1) << cand_id;
            out_cmd_d.first_pid   = pid_q[cand_id];
            out_cmd_d.pbs_cnt_max = pmax_q[cand_id];
            out_cmd_d.ks_loop     = col_q[cand_id];
            col_d[cand_id]        = col_q[cand_id] + KS_LOOP_W'(1);
            if (col_q[cand_id] == LAST_COL) begin
                pend_d[cand_id] = 1'b1;
            end
            rr_d = (cand_id == LAST_SLOT) ? '0 : cand_id + TOTAL_BATCH_NB_W'(1);
        end

        // The released slot is never the one being allocated: allocation saw it active.
        if (last_acc) begin
            active_d[out_cmd_q.batch_id] = 1'b0;
            pend_d[out_cmd_q.batch_id]   = 1'b0;
            done_d                       = 1'b1;
            done_id_d                    = out_cmd_q.batch_id;
        end

        if (reset_cache) begin
            active_d  = '0;
            pend_d    = '0;
            rr_d      = '0;
            out_vld_d = 1'b0;
            done_d    = 1'b0;
            done_id_d = done_id_q;
        end
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            active_q  <= '0;
            pend_q    <= '0;
            rr_q      <= '0;
            out_vld_q <= 1'b0;
            out_cmd_q <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            for (int i = 0; i < BATCH_NB; i++) begin
                pid_q[i]  <= '0;
                pmax_q[i] <= '0;
                col_q[i]  <= '0;
            end
        end else begin
            active_q  <= active_d;
            pend_q    <= pend_d;
            rr_q      <= rr_d;
            out_vld_q <= out_vld_d;
            out_cmd_q <= out_cmd_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            pid_q     <= pid_d;
            pmax_q    <= pmax_d;
            col_q     <= col_d;
        end
    end

    assign ffifo_feed_vld  = out_vld_q;
    assign ffifo_feed_pcmd = out_cmd_q;
    assign batch_done      = done_q;
    assign batch_done_id   = done_id_q;

endmodule

// File: tb/tb_pep_ks_ctrl_cmd_gen.sv
// Scoreboard bench for pep_ks_ctrl_cmd_gen with 2 slots, 4 columns, 8 PBS per batch, 16 PIDs.
module tb_pep_ks_ctrl_cmd_gen;

    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          a_rst = 1'b1;
    logic          reset_cache = 1'b0;
    logic [3:0]    seq_ks_first_pid = '0;
    logic [3:0]    seq_ks_pbs_nb = '0;
    logic          seq_ks_vld = 1'b0;
    logic          seq_ks_rdy;
    logic [0:0]    seq_ks_batch_id;
    logic [CW-1:0] ffifo_feed_pcmd;
    logic          ffifo_feed_vld;
    logic          ffifo_feed_rdy = 1'b1;
    logic          batch_done;
    logic [0:0]    batch_done_id;

    int errs = 0;
    int checks = 0;
    int arst_cnt = 0;

    logic [CW-1:0] exp_cmd_q[$];
    int            exp_done_q[$];
    int            exp_alloc_q[$];

    pep_ks_ctrl_cmd_gen #(
        .TOTAL_BATCH_NB(2),
        .KS_BLOCK_COL_NB(4),
        .BATCH_PBS_NB(8),
        .TOTAL_PBS_NB(16)
    ) dut (
        .clk(clk),
        .a_rst(a_rst),
        .reset_cache(reset_cache),
        .seq_ks_first_pid(seq_ks_first_pid),
        .seq_ks_pbs_nb(seq_ks_pbs_nb),
        .seq_ks_vld(seq_ks_vld),
        .seq_ks_rdy(seq_ks_rdy),
        .seq_ks_batch_id(seq_ks_batch_id),
        .ffifo_feed_pcmd(ffifo_feed_pcmd),
        .ffifo_feed_vld(ffifo_feed_vld),
        .ffifo_feed_rdy(ffifo_feed_rdy),
        .batch_done(batch_done),
        .batch_done_id(batch_done_id)
    );

    always #5 clk = ~clk;

    // Layout MSB..LSB: batch_id(1), batch_id_1h(2), first_pid(4), pbs_cnt_max(3), ks_loop(2).
    function automatic logic [CW-1:0] mk(input int id, input int pid, input int pmax, input int lp);
        logic [1:0] oh;
        oh = (id == 0) ? 2'b01 : 2'b10;
        return {1'(id), oh, 4'(pid), 3'(pmax), 2'(lp)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_batch(input int id, input int pid, input int nb);
        exp_alloc_q.push_back(id);
        for (int l = 0; l < 4; l++) exp_cmd_q.push_back(mk(id, pid, nb - 1, l));
        exp_done_q.push_back(id);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input int pid, input int nb);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        seq_ks_first_pid = 4'(pid);
        seq_ks_pbs_nb    = 4'(nb);
        seq_ks_vld       = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (seq_ks_rdy) ok = 1'b1;
            n++;
        end
        if (!ok) begin
            errs++;
            checks++;
            $display("FAIL req_timeout: seq_ks_rdy stayed 0 required 1");
        end
        step();
        seq_ks_vld = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_cmd_q.size() + exp_done_q.size() + exp_alloc_q.size()) != 0 && n < 200) begin
            step();
            n++;
        end
        chk("drain_left", exp_cmd_q.size() + exp_done_q.size() + exp_alloc_q.size(), 0);
        repeat (3) step();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a handshake or pulse.
    initial begin
        logic          hold;
        logic [CW-1:0] hold_cmd;
        int            hold_rc;
        hold     = 1'b0;
        hold_cmd = '0;
        hold_rc  = 0;
        forever begin
            @(negedge clk);
            if (hold && hold_rc == arst_cnt && !a_rst) begin
                chk("hold_vld", ffifo_feed_vld, 1);
                chk("hold_pcmd", ffifo_feed_pcmd, hold_cmd);
            end
            hold     = ffifo_feed_vld && !ffifo_feed_rdy && !reset_cache && !a_rst;
            hold_cmd = ffifo_feed_pcmd;
            hold_rc  = arst_cnt;
            if (!a_rst && ffifo_feed_vld && ffifo_feed_rdy) begin
                if (exp_cmd_q.size() == 0) begin
                    errs++;
                    checks++;
                    $display("FAIL cmd: unexpected %0h required none", ffifo_feed_pcmd);
                end else begin
                    chk("cmd", ffifo_feed_pcmd, exp_cmd_q.pop_front());
                end
            end
            if (!a_rst && batch_done) begin
                if (exp_done_q.size() == 0) begin
                    errs++;
                    checks++;
                    $display("FAIL done: unexpected id %0d required none", batch_done_id);
                end else begin
                    chk("done_id", batch_done_id, exp_done_q.pop_front());
                end
            end
            if (!a_rst && seq_ks_vld && seq_ks_rdy) begin
                if (exp_alloc_q.size() == 0) begin
                    errs++;
                    checks++;
                    $display("FAIL alloc: unexpected id %0d required none", seq_ks_batch_id);
                end else begin
                    chk("alloc_id", seq_ks_batch_id, exp_alloc_q.pop_front());
                end
            end
        end
    end

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", ffifo_feed_vld, 0);
        chk("rst_pcmd", ffifo_feed_pcmd, 0);
        chk("rst_done", batch_done, 0);
        chk("rst_done_id", batch_done_id, 0);
        chk("rst_batch_id", seq_ks_batch_id, 0);
        step();
        a_rst = 1'b0;
        @(negedge clk);
        chk("rst_rdy", seq_ks_rdy, 1);
        step();

        // Single batch and first-command latency
        push_batch(0, 5, 3);
        send_req(5, 3);
        @(negedge clk);
        chk("lat_n1_vld", ffifo_feed_vld, 0);
        @(negedge clk);
        chk("lat_n2_vld", ffifo_feed_vld, 1);
        step();
        drain();

        // Two interleaved batches, third request stalls until a slot frees
        exp_alloc_q.push_back(0);
        exp_alloc_q.push_back(1);
        exp_alloc_q.push_back(0);
        for (int l = 0; l < 4; l++) begin
            exp_cmd_q.push_back(mk(0, 1, 7, l));
            exp_cmd_q.push_back(mk(1, 15, 3, l));
        end
        for (int l = 0; l < 4; l++) exp_cmd_q.push_back(mk(0, 3, 1, l));
        exp_done_q.push_back(0);
        exp_done_q.push_back(1);
        exp_done_q.push_back(0);
        send_req(1, 8);
        send_req(15, 4);
        @(negedge clk);
        chk("full_rdy", seq_ks_rdy, 0);
        step();
        send_req(3, 2);
        drain();

        // Backpressure mid-batch
        push_batch(0, 2, 5);
        send_req(2, 5);
        step();
        step();
        ffifo_feed_rdy = 1'b0;
        repeat (5) step();
        ffifo_feed_rdy = 1'b1;
        drain();

        // reset_cache while ks_loop=1 is presented
        exp_alloc_q.push_back(0);
        exp_cmd_q.push_back(mk(0, 7, 1, 0));
        send_req(7, 2);
        step();
        step();
        ffifo_feed_rdy = 1'b0;
        reset_cache    = 1'b1;
        @(negedge clk);
        chk("rc_loop1", ffifo_feed_pcmd[1:0], 1);
        chk("rc_rdy_low", seq_ks_rdy, 0);
        step();
        reset_cache    = 1'b0;
        ffifo_feed_rdy = 1'b1;
        @(negedge clk);
        chk("rc_vld", ffifo_feed_vld, 0);
        chk("rc_done", batch_done, 0);
        chk("rc_rdy", seq_ks_rdy, 1);
        step();
        push_batch(0, 4, 1);
        send_req(4, 1);
        drain();

        // Asynchronous reset mid-stream
        exp_alloc_q.push_back(0);
        ffifo_feed_rdy = 1'b0;
        send_req(6, 3);
        step();
        @(negedge clk);
        #2;
        a_rst = 1'b1;
        arst_cnt++;
        #1;
        chk("ar_vld", ffifo_feed_vld, 0);
        chk("ar_pcmd", ffifo_feed_pcmd, 0);
        chk("ar_done", batch_done, 0);
        chk("ar_batch_id", seq_ks_batch_id, 0);
        chk("ar_rdy", seq_ks_rdy, 1);
        step();
        a_rst          = 1'b0;
        ffifo_feed_rdy = 1'b1;
        @(negedge clk);
        chk("ar_post_vld", ffifo_feed_vld, 0);
        step();
        push_batch(0, 15, 8);
        send_req(15, 8);
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
